// File: rtl/adder_sum_stage_pkg.sv
// ---------------------------------------------------------------------------
// adder_sum_stage_pkg : shared widths, result-word flag layout, skid states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package adder_sum_stage_pkg;

  localparam int LEN_DATA  = 32;

  // Flag positions inside the 4-bit flag field placed directly above the sum
  localparam int FLAG_N    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_V    = 2;
  localparam int FLAG_C    = 3;
  localparam int NUM_FLAGS = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/adder_skid_buf.sv
// ---------------------------------------------------------------------------
// adder_skid_buf : 2-entry valid/ready skid buffer with registered ready
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adder_skid_buf
  import adder_sum_stage_pkg::*;
#(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  r_state;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic [W-1:0] r_skid_data;

  logic         w_accept;
  logic         w_drain;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out_data  <= in_data;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_drain) begin
            r_skid_data <= in_data;
            r_in_ready  <= 1'b0;
            r_state     <= ST_FULL;
          end else if (!w_accept && w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end else if (w_accept && w_drain) begin
            r_out_data  <= in_data;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can change anything
          if (w_drain) begin
            r_out_data  <= r_skid_data;
            r_in_ready  <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: rtl/adder_sum_stage.sv
// ---------------------------------------------------------------------------
// adder_sum_stage : prefix-adder final stage (carries, sum, flags) + skid buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adder_sum_stage
  import adder_sum_stage_pkg::*;
#(
  parameter int LEN = LEN_DATA
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] generate_in,
  input  logic [LEN-1:0] propogate_in,
  input  logic [LEN-1:0] half_sum_in,
  input  logic           carry_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] sum_out,
  output logic           carry_out,
  output logic           overflow_out,
  output logic           zero_out,
  output logic           negative_out
);

  localparam int W = LEN + NUM_FLAGS;

  logic [LEN:0]   w_carry;
  logic [LEN-1:0] w_sum;
  logic [W-1:0]   w_result;
  logic [W-1:0]   w_out_word;

  // Group G/P already span bits [i:0], so each carry needs only the carry-in term
  assign w_carry = {generate_in | (propogate_in & {LEN{carry_in}}), carry_in};
  assign w_sum   = half_sum_in ^ w_carry[LEN-1:0];

  always_comb begin
    w_result                = '0;
    w_result[LEN-1:0]       = w_sum;
    w_result[LEN + FLAG_C]  = w_carry[LEN];
    w_result[LEN + FLAG_V]  = w_carry[LEN] ^ w_carry[LEN-1];
    w_result[LEN + FLAG_Z]  = ~|w_sum;
    w_result[LEN + FLAG_N]  = w_sum[LEN-1];
  end

  adder_skid_buf #(
    .W (W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_word)
  );

  assign sum_out      = w_out_word[LEN-1:0];
  assign carry_out    = w_out_word[LEN + FLAG_C];
  assign overflow_out = w_out_word[LEN + FLAG_V];
  assign zero_out     = w_out_word[LEN + FLAG_Z];
  assign negative_out = w_out_word[LEN + FLAG_N];

endmodule

`default_nettype wire
